hci_copy_sink: RTL and testbench

Terminating end of an HCI fault-detection copy chain. It receives the main request stream and a duplicated copy stream from two redundant HCI module chains. The main stream is forwarded to the downstream target, and every response is mirrored back to both chains. Each cycle the block compares the request-side fields of the two streams; mismatches are registered, counted and captured until software clears them.

---
 rtl/hci_copy_sink_if.sv | 51 +++++
 rtl/hci_copy_sink.sv | 138 +++++++++++++
 tb/tb_hci_copy_sink.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hci_copy_sink_if.sv
// HCI core request/response bundle shared by the copy chains.
// target receives requests; initiator issues them.
interface hci_core_intf #(
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 32,
  parameter int unsigned BW  = 8,
  parameter int unsigned UW  = 2,
  parameter int unsigned IW  = 4,
  parameter int unsigned EW  = 7,
  parameter int unsigned EHW = 1
) ();

  localparam int unsigned BEW = DW / BW;

  logic           req;
  logic [EHW-1:0] ereq;
  logic [EHW-1:0] r_eready;
  logic [EW-1:0]  ecc;
  logic [AW-1:0]  add;
  logic           wen;
  logic [DW-1:0]  data;
  logic [BEW-1:0] be;
  logic           r_ready;
  logic [UW-1:0]  user;
  logic [IW-1:0]  id;

  logic           gnt;
  logic [DW-1:0]  r_data;
  logic           r_valid;
  logic [UW-1:0]  r_user;
  logic [IW-1:0]  r_id;
  logic           r_opc;
  logic [EHW-1:0] egnt;
  logic [EHW-1:0] r_evalid;
  logic [EW-1:0]  r_ecc;

  modport target (
    input  req, ereq, r_eready, ecc, add, wen,
    input  data, be, r_ready, user, id,
    output gnt, r_data, r_valid, r_user, r_id,
    output r_opc, egnt, r_evalid, r_ecc
  );

  modport initiator (
    output req, ereq, r_eready, ecc, add, wen,
    output data, be, r_ready, user, id,
    input  gnt, r_data, r_valid, r_user, r_id,
    input  r_opc, egnt, r_evalid, r_ecc
  );

endinterface

// File: rtl/hci_copy_sink.sv
// Copy-chain sink: forwards main stream, mirrors responses,
// and flags any request-side divergence between the chains.
module hci_copy_sink #(
  parameter bit          REG_COMPARE = 1'b1,
  parameter int unsigned FAULT_CNT_W = 16,
  parameter int unsigned AW          = 32
) (
  input  logic                   clk_i,
  input  logic                   clear_i,
  hci_core_intf.target           tcdm_main,
  hci_core_intf.target           tcdm_copy,
  hci_core_intf.initiator        tcdm_out,
  input  logic                   fault_clr_i,
  output logic                   fault_detected_o,
  output logic                   fault_pulse_o,
  output logic [FAULT_CNT_W-1:0] fault_count_o,
  output logic [10:0]            fault_field_o,
  output logic [AW-1:0]          fault_add_o
);

  localparam logic [FAULT_CNT_W-1:0] CNT_MAX = '1;

  logic [10:0]            mm;
  logic [10:0]            ev_mm;
  logic [AW-1:0]          ev_add;
  logic                   armed_q;
  logic                   hit;
  logic                   sticky_q;
  logic [FAULT_CNT_W-1:0] cnt_q;
  logic [10:0]            field_q;
  logic [AW-1:0]          add_q;

  assign tcdm_out.req      = tcdm_main.req;
  assign tcdm_out.ereq     = tcdm_main.ereq;
  assign tcdm_out.r_eready = tcdm_main.r_eready;
  assign tcdm_out.ecc      = tcdm_main.ecc;
  assign tcdm_out.add      = tcdm_main.add;
  assign tcdm_out.wen      = tcdm_main.wen;
  assign tcdm_out.data     = tcdm_main.data;
  assign tcdm_out.be       = tcdm_main.be;
  assign tcdm_out.r_ready  = tcdm_main.r_ready;
  assign tcdm_out.user     = tcdm_main.user;
  assign tcdm_out.id       = tcdm_main.id;

  assign tcdm_main.gnt      = tcdm_out.gnt;
  assign tcdm_main.r_data   = tcdm_out.r_data;
  assign tcdm_main.r_valid  = tcdm_out.r_valid;
  assign tcdm_main.r_user   = tcdm_out.r_user;
  assign tcdm_main.r_id     = tcdm_out.r_id;
  assign tcdm_main.r_opc    = tcdm_out.r_opc;
  assign tcdm_main.egnt     = tcdm_out.egnt;
  assign tcdm_main.r_evalid = tcdm_out.r_evalid;
  assign tcdm_main.r_ecc    = tcdm_out.r_ecc;

  assign tcdm_copy.gnt      = tcdm_out.gnt;
  assign tcdm_copy.r_data   = tcdm_out.r_data;
  assign tcdm_copy.r_valid  = tcdm_out.r_valid;
  assign tcdm_copy.r_user   = tcdm_out.r_user;
  assign tcdm_copy.r_id     = tcdm_out.r_id;
  assign tcdm_copy.r_opc    = tcdm_out.r_opc;
  assign tcdm_copy.egnt     = tcdm_out.egnt;
  assign tcdm_copy.r_evalid = tcdm_out.r_evalid;
  assign tcdm_copy.r_ecc    = tcdm_out.r_ecc;

  always_comb begin
    mm     = '0;
    mm[0]  = tcdm_main.req      != tcdm_copy.req;
    mm[1]  = tcdm_main.ereq     != tcdm_copy.ereq;
    mm[2]  = tcdm_main.r_eready != tcdm_copy.r_eready;
    mm[3]  = tcdm_main.ecc      != tcdm_copy.ecc;
    mm[4]  = tcdm_main.add      != tcdm_copy.add;
    mm[5]  = tcdm_main.wen      != tcdm_copy.wen;
    mm[6]  = tcdm_main.data     != tcdm_copy.data;
    mm[7]  = tcdm_main.be       != tcdm_copy.be;
    mm[8]  = tcdm_main.r_ready  != tcdm_copy.r_ready;
    mm[9]  = tcdm_main.user     != tcdm_copy.user;
    mm[10] = tcdm_main.id       != tcdm_copy.id;
  end

  if (REG_COMPARE) begin : g_reg
    logic [10:0]   mm_q;
    logic [AW-1:0] mm_add_q;

    always_ff @(posedge clk_i) begin
      if (clear_i) begin
        mm_q     <= '0;
        mm_add_q <= '0;
      end else begin
        mm_q     <= mm;
        mm_add_q <= tcdm_main.add;
      end
    end

    assign ev_mm  = mm_q;
    assign ev_add = mm_add_q;
  end else begin : g_comb
    assign ev_mm  = mm;
    assign ev_add = tcdm_main.add;
  end

  // blanks the first cycle after clear so outputs stay quiet there
  always_ff @(posedge clk_i) begin
    if (clear_i) armed_q <= 1'b0;
    else         armed_q <= 1'b1;
  end

  assign hit = armed_q & ~clear_i & (|ev_mm);

  // a hit outranks fault_clr_i: clear then record this event
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      field_q  <= '0;
      add_q    <= '0;
    end else if (hit) begin
      sticky_q <= 1'b1;
      if (fault_clr_i)          cnt_q <= {{(FAULT_CNT_W-1){1'b0}}, 1'b1};
      else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      if (!sticky_q || fault_clr_i) begin
        field_q <= ev_mm;
        add_q   <= ev_add;
      end
    end else if (fault_clr_i) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      field_q  <= '0;
      add_q    <= '0;
    end
  end

  assign fault_pulse_o    = hit;
  assign fault_detected_o = sticky_q & ~clear_i;
  assign fault_count_o    = clear_i ? '0 : cnt_q;
  assign fault_field_o    = clear_i ? '0 : field_q;
  assign fault_add_o      = clear_i ? '0 : add_q;

endmodule

// File: tb/tb_hci_copy_sink.sv
// Random + directed bench for hci_copy_sink, both compare modes,
// checked by a history-based reference model through a scoreboard.
module tb_hci_copy_sink;

  typedef struct packed {
    logic       req;
    logic       ereq;
    logic       r_eready;
    logic [6:0] ecc;
    logic [31:0] add;
    logic       wen;
    logic [31:0] data;
    logic [3:0] be;
    logic       r_ready;
    logic [1:0] user;
    logic [3:0] id;
  } req_t;

  typedef struct packed {
    logic       gnt;
    logic [31:0] r_data;
    logic       r_valid;
    logic [1:0] r_user;
    logic [3:0] r_id;
    logic       r_opc;
    logic       egnt;
    logic       r_evalid;
    logic [6:0] r_ecc;
  } rsp_t;

  typedef struct packed {
    logic        pulse;
    logic        det;
    logic [3:0]  cnt;
    logic [10:0] field;
    logic [31:0] add;
    req_t        out;
    rsp_t        rsp;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clear = 1'b1;
  logic fclr  = 1'b0;
  req_t mreq  = '0;
  req_t creq  = '0;
  rsp_t rsp   = '0;

  hci_core_intf m1 ();
  hci_core_intf c1 ();
  hci_core_intf o1 ();
  hci_core_intf m0 ();
  hci_core_intf c0 ();
  hci_core_intf o0 ();

  assign {m1.req, m1.ereq, m1.r_eready, m1.ecc, m1.add, m1.wen,
          m1.data, m1.be, m1.r_ready, m1.user, m1.id} = mreq;
  assign {m0.req, m0.ereq, m0.r_eready, m0.ecc, m0.add, m0.wen,
          m0.data, m0.be, m0.r_ready, m0.user, m0.id} = mreq;
  assign {c1.req, c1.ereq, c1.r_eready, c1.ecc, c1.add, c1.wen,
          c1.data, c1.be, c1.r_ready, c1.user, c1.id} = creq;
  assign {c0.req, c0.ereq, c0.r_eready, c0.ecc, c0.add, c0.wen,
          c0.data, c0.be, c0.r_ready, c0.user, c0.id} = creq;
  assign {o1.gnt, o1.r_data, o1.r_valid, o1.r_user, o1.r_id,
          o1.r_opc, o1.egnt, o1.r_evalid, o1.r_ecc} = rsp;
  assign {o0.gnt, o0.r_data, o0.r_valid, o0.r_user, o0.r_id,
          o0.r_opc, o0.egnt, o0.r_evalid, o0.r_ecc} = rsp;

  logic        pulse1, det1, pulse0, det0;
  logic [3:0]  cnt1, cnt0;
  logic [10:0] field1, field0;
  logic [31:0] add1, add0;

  hci_copy_sink #(
    .REG_COMPARE(1'b1), .FAULT_CNT_W(4), .AW(32)
  ) dut1 (
    .clk_i(clk), .clear_i(clear),
    .tcdm_main(m1), .tcdm_copy(c1), .tcdm_out(o1),
    .fault_clr_i(fclr), .fault_detected_o(det1),
    .fault_pulse_o(pulse1), .fault_count_o(cnt1),
    .fault_field_o(field1), .fault_add_o(add1)
  );

  hci_copy_sink #(
    .REG_COMPARE(1'b0), .FAULT_CNT_W(4), .AW(32)
  ) dut0 (
    .clk_i(clk), .clear_i(clear),
    .tcdm_main(m0), .tcdm_copy(c0), .tcdm_out(o0),
    .fault_clr_i(fclr), .fault_detected_o(det0),
    .fault_pulse_o(pulse0), .fault_count_o(cnt0),
    .fault_field_o(field0), .fault_add_o(add0)
  );

  req_t out1_w, out0_w;
  rsp_t rm1_w, rc1_w, rm0_w, rc0_w;

  assign out1_w = {o1.req, o1.ereq, o1.r_eready, o1.ecc, o1.add,
                   o1.wen, o1.data, o1.be, o1.r_ready, o1.user, o1.id};
  assign out0_w = {o0.req, o0.ereq, o0.r_eready, o0.ecc, o0.add,
                   o0.wen, o0.data, o0.be, o0.r_ready, o0.user, o0.id};
  assign rm1_w = {m1.gnt, m1.r_data, m1.r_valid, m1.r_user, m1.r_id,
                  m1.r_opc, m1.egnt, m1.r_evalid, m1.r_ecc};
  assign rc1_w = {c1.gnt, c1.r_data, c1.r_valid, c1.r_user, c1.r_id,
                  c1.r_opc, c1.egnt, c1.r_evalid, c1.r_ecc};
  assign rm0_w = {m0.gnt, m0.r_data, m0.r_valid, m0.r_user, m0.r_id,
                  m0.r_opc, m0.egnt, m0.r_evalid, m0.r_ecc};
  assign rc0_w = {c0.gnt, c0.r_data, c0.r_valid, c0.r_user, c0.r_id,
                  c0.r_opc, c0.egnt, c0.r_evalid, c0.r_ecc};

  // per-cycle stimulus history: which fields differed, main add, controls
  logic [10:0] mm_h[$];
  logic [31:0] add_h[$];
  bit          clr_h[$];
  bit          fclr_h[$];
  exp_t        q1[$];
  exp_t        q0[$];

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // a compare event seen at cycle k: registered mode looks one back
  function automatic bit hit_at(bit r, int k);
    if (k < 1) return 1'b0;
    if (clr_h[k] || clr_h[k-1]) return 1'b0;
    return r ? (mm_h[k-1] != 0) : (mm_h[k] != 0);
  endfunction

  function automatic exp_t model(bit r, int n, req_t m, rsp_t rs);
    exp_t e;
    int   tot;
    e     = '0;
    e.out = m;
    e.rsp = rs;
    if (clr_h[n]) return e;
    e.pulse = hit_at(r, n);
    tot = 0;
    for (int k = n - 1; k >= 0; k--) begin
      if (hit_at(r, k)) begin
        tot++;
        e.field = r ? mm_h[k-1] : mm_h[k];
        e.add   = r ? add_h[k-1] : add_h[k];
      end
      if (clr_h[k] || fclr_h[k]) break;
    end
    e.det = (tot > 0);
    e.cnt = (tot > 15) ? 4'd15 : 4'(tot);
    return e;
  endfunction

  function automatic req_t flip(req_t m, int f);
    req_t c;
    c = m;
    case (f)
      0:  c.req      = ~c.req;
      1:  c.ereq     = ~c.ereq;
      2:  c.r_eready = ~c.r_eready;
      3:  c.ecc      = c.ecc ^ 7'h1;
      4:  c.add      = c.add ^ 32'h4;
      5:  c.wen      = ~c.wen;
      6:  c.data     = c.data ^ (32'h1 << $urandom_range(31, 0));
      7:  c.be       = c.be ^ 4'h1;
      8:  c.r_ready  = ~c.r_ready;
      9:  c.user     = c.user ^ 2'h1;
      10: c.id       = c.id ^ 4'h1;
      default: ;
    endcase
    return c;
  endfunction

  // f < 0: copy identical to main; otherwise field f diverges
  task automatic step(int f, bit fc, bit cl);
    logic [95:0] rv;
    logic [63:0] rr;
    req_t        m;
    rsp_t        r;
    logic [10:0] mask;
    int          n;
    rv = {$urandom, $urandom, $urandom};
    rr = {$urandom, $urandom};
    m  = rv[85:0];
    r  = rr[49:0];
    if (f == 4) m.add = 32'h1000_0000;
    mask = (f >= 0) ? (11'h1 << f) : 11'h0;
    @(posedge clk);
    #1;
    mreq  = m;
    creq  = (f >= 0) ? flip(m, f) : m;
    rsp   = r;
    fclr  = fc;
    clear = cl;
    mm_h.push_back(mask);
    add_h.push_back(m.add);
    clr_h.push_back(cl);
    fclr_h.push_back(fc);
    n = mm_h.size() - 1;
    q1.push_back(model(1'b1, n, m, r));
    q0.push_back(model(1'b0, n, m, r));
  endtask

  always @(negedge clk) begin
    if (!done && q1.size() > 0 && q0.size() > 0) begin
      exp_t e1, e0;
      e1 = q1.pop_front();
      e0 = q0.pop_front();
      chk("r1.pulse", pulse1, e1.pulse);
      chk("r1.detected", det1, e1.det);
      chk("r1.count", cnt1, e1.cnt);
      chk("r1.field", field1, e1.field);
      chk("r1.add", add1, e1.add);
      chk("r1.out_req", out1_w, e1.out);
      chk("r1.rsp_main", rm1_w, e1.rsp);
      chk("r1.rsp_copy", rc1_w, e1.rsp);
      chk("r0.pulse", pulse0, e0.pulse);
      chk("r0.detected", det0, e0.det);
      chk("r0.count", cnt0, e0.cnt);
      chk("r0.field", field0, e0.field);
      chk("r0.add", add0, e0.add);
      chk("r0.out_req", out0_w, e0.out);
      chk("r0.rsp_main", rm0_w, e0.rsp);
      chk("r0.rsp_copy", rc0_w, e0.rsp);
    end
  end

  initial begin
    repeat (3) step(-1, 1'b0, 1'b1);
    @(negedge clk);
    chk("reset_count", cnt1, 4'd0);
    chk("reset_detected", det1, 1'b0);

    repeat (1000) step(-1, 1'b0, 1'b0);
    @(negedge clk);
    chk("clean_count", cnt1, 4'd0);

    step(4, 1'b0, 1'b0);
    step(-1, 1'b0, 1'b0);
    @(negedge clk);
    chk("add_pulse_t1", pulse1, 1'b1);
    step(-1, 1'b0, 1'b0);
    @(negedge clk);
    chk("add_pulse_t2", pulse1, 1'b0);
    chk("add_field", field1, 11'h010);
    chk("add_addr", add1, 32'h1000_0000);
    chk("add_count", cnt1, 4'd1);

    step(-1, 1'b1, 1'b0);
    step(-1, 1'b0, 1'b0);
    step(6, 1'b0, 1'b0);
    step(-1, 1'b0, 1'b0);
    step(-1, 1'b0, 1'b0);
    step(7, 1'b0, 1'b0);
    repeat (3) step(-1, 1'b0, 1'b0);
    @(negedge clk);
    chk("data_be_count", cnt1, 4'd2);
    chk("data_be_field", field1, 11'h040);
    chk("data_be_sticky", det1, 1'b1);

    step(-1, 1'b1, 1'b0);
    repeat (20) step(8, 1'b0, 1'b0);
    repeat (2) step(-1, 1'b0, 1'b0);
    @(negedge clk);
    chk("sat_count", cnt1, 4'd15);
    chk("sat_sticky", det1, 1'b1);

    step(10, 1'b0, 1'b0);
    step(-1, 1'b1, 1'b0);
    step(-1, 1'b0, 1'b0);
    @(negedge clk);
    chk("clr_hit_count", cnt1, 4'd1);
    chk("clr_hit_field", field1, 11'h400);
    chk("clr_hit_sticky", det1, 1'b1);
    step(-1, 1'b1, 1'b0);
    step(-1, 1'b0, 1'b0);
    @(negedge clk);
    chk("clr_only_zero", {det1, cnt1, field1, add1}, '0);

    step(6, 1'b0, 1'b1);
    step(-1, 1'b0, 1'b0);
    @(negedge clk);
    chk("clear_mm_zero",
        {pulse0, det0, cnt0, field0, add0}, '0);

    for (int i = 0; i < 300; i++) begin
      int  f;
      bit  fc, cl;
      f  = ($urandom_range(9, 0) == 0) ? int'($urandom_range(10, 0)) : -1;
      fc = ($urandom_range(19, 0) == 0);
      cl = ($urandom_range(49, 0) == 0);
      step(f, fc, cl);
    end
    repeat (3) step(-1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    done = 1'b1;
    chk("queue_drain", q1.size() + q0.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
